sevenseg_scanner: RTL and testbench

//  Consumes the four glyph codes produced by the display driver (digit3 leftmost) and time-multiplexes them onto
//  a 4-digit common-anode seven-segment display. Snapshots digits once per frame (tear-free), decodes

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_glyph_rom.sv | 32 +++
 rtl/sevenseg_scanner.sv | 113 +++++++++++
 tb/tb_sevenseg_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared glyph codes and segment patterns for the seven-segment scanner.
// Patterns are active-high {g,f,e,d,c,b,a}; pins are driven with the complement.
package seg_pkg;

    localparam logic [3:0] GLYPH_R     = 4'hA;
    localparam logic [3:0] GLYPH_N     = 4'hB;
    localparam logic [3:0] GLYPH_O     = 4'hC;
    localparam logic [3:0] GLYPH_D     = 4'hD;
    localparam logic [3:0] GLYPH_E     = 4'hE;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    localparam logic [6:0] SEG_PAT_0     = 7'h3F;
    localparam logic [6:0] SEG_PAT_1     = 7'h06;
    localparam logic [6:0] SEG_PAT_2     = 7'h5B;
    localparam logic [6:0] SEG_PAT_3     = 7'h4F;
    localparam logic [6:0] SEG_PAT_4     = 7'h66;
    localparam logic [6:0] SEG_PAT_5     = 7'h6D;
    localparam logic [6:0] SEG_PAT_6     = 7'h7D;
    localparam logic [6:0] SEG_PAT_7     = 7'h07;
    localparam logic [6:0] SEG_PAT_8     = 7'h7F;
    localparam logic [6:0] SEG_PAT_9     = 7'h6F;
    localparam logic [6:0] SEG_PAT_R     = 7'h50;
    localparam logic [6:0] SEG_PAT_N     = 7'h54;
    localparam logic [6:0] SEG_PAT_O     = 7'h5C;
    localparam logic [6:0] SEG_PAT_D     = 7'h5E;
    localparam logic [6:0] SEG_PAT_E     = 7'h79;
    localparam logic [6:0] SEG_PAT_BLANK = 7'h00;

    // Active-low pin value with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph decoder: 4-bit code to active-high segment pattern.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] pattern_o
);

    always_comb begin
        pattern_o = SEG_PAT_BLANK;
        case (code_i)
            4'h0:        pattern_o = SEG_PAT_0;
            4'h1:        pattern_o = SEG_PAT_1;
            4'h2:        pattern_o = SEG_PAT_2;
            4'h3:        pattern_o = SEG_PAT_3;
            4'h4:        pattern_o = SEG_PAT_4;
            4'h5:        pattern_o = SEG_PAT_5;
            4'h6:        pattern_o = SEG_PAT_6;
            4'h7:        pattern_o = SEG_PAT_7;
            4'h8:        pattern_o = SEG_PAT_8;
            4'h9:        pattern_o = SEG_PAT_9;
            GLYPH_R:     pattern_o = SEG_PAT_R;
            GLYPH_N:     pattern_o = SEG_PAT_N;
            GLYPH_O:     pattern_o = SEG_PAT_O;
            GLYPH_D:     pattern_o = SEG_PAT_D;
            GLYPH_E:     pattern_o = SEG_PAT_E;
            GLYPH_BLANK: pattern_o = SEG_PAT_BLANK;
            default:     pattern_o = SEG_PAT_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexes four glyphs onto a common-anode display with per-frame snapshots,
// leading-zero blanking, anti-ghost dead time and optional blinking.
module sevenseg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = $clog2(2 * BLINK_FRAMES);

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
    localparam logic [BW-1:0] PHASE_LAST = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] PHASE_DARK = BW'(BLINK_FRAMES);

    logic [PW-1:0]     presc_q, presc_d;
    logic [1:0]        slot_q, slot_d;
    logic [3:0][3:0]   shadow_q, shadow_d;
    logic              blink_q, blink_d;
    logic [BW-1:0]     phase_q, phase_d;
    logic              tick_q, tick_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    logic              term_cnt;
    logic              frame_start;
    logic [3:0]        cur_code;
    logic [6:0]        cur_pattern;
    logic              lz_blank;
    logic              dark;

    seg_glyph_rom u_rom (
        .code_i    (cur_code),
        .pattern_o (cur_pattern)
    );

    always_comb begin
        term_cnt    = (presc_q == PRESC_LAST);
        frame_start = term_cnt && (slot_q == 2'd0);

        presc_d  = term_cnt ? '0 : presc_q + 1'b1;
        // Slot runs 3,2,1,0 and wraps back to 3 through the 2-bit underflow.
        slot_d   = term_cnt ? slot_q - 2'd1 : slot_q;
        shadow_d = shadow_q;
        blink_d  = blink_q;
        phase_d  = phase_q;
        tick_d   = frame_start;

        if (frame_start) begin
            shadow_d = {digit3, digit2, digit1, digit0};
            blink_d  = blink_en;
            phase_d  = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        end
    end

    always_comb begin
        cur_code = shadow_q[slot_q];
        lz_blank = (LZ_BLANK != 0) &&
                   (((slot_q == 2'd3) && (shadow_q[3] == 4'd0)) ||
                    ((slot_q == 2'd2) && (shadow_q[3] == 4'd0) && (shadow_q[2] == 4'd0)));
        dark     = blink_q && (phase_q >= PHASE_DARK);

        an_d  = 4'hF;
        seg_d = SEG_OFF;
        // Blanked slots still light their anode so every digit gets equal on-time.
        if (!dark && (presc_q >= BLANK_LIM)) begin
            an_d  = ~(4'b0001 << slot_q);
            seg_d = lz_blank ? SEG_OFF : ~cur_pattern;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            slot_q   <= 2'd3;
            shadow_q <= {4{GLYPH_BLANK}};
            blink_q  <= 1'b0;
            phase_q  <= '0;
            tick_q   <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= 4'hF;
        end else begin
            presc_q  <= presc_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            tick_q   <= tick_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench: a cycle-count reference model queues expected pin values, a monitor checks them.
module tb_sevenseg_scanner;

    localparam int DIV   = 4;
    localparam int BLK   = 1;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d3, d2, d1, d0;
    logic       blink_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    int total = 0;
    int bad = 0;

    exp_t       q[$];
    int         n;
    logic [3:0] m_sh [4];
    logic       m_blink;
    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h50, 7'h54, 7'h5C, 7'h5E, 7'h79, 7'h00};

    sevenseg_scanner #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK),
        .BLINK_FRAMES (BF),
        .LZ_BLANK     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit3     (d3),
        .digit2     (d2),
        .digit1     (d1),
        .digit0     (d0),
        .blink_en   (blink_en),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected pins after the edge that leaves state index st (cycles since reset release).
    function automatic exp_t model_out(input int st);
        exp_t e;
        int   presc;
        int   sl;
        int   ph;
        logic blank;
        presc  = st % DIV;
        sl     = 3 - ((st / DIV) % 4);
        ph     = (st / FRAME) % (2 * BF);
        e.an   = 4'hF;
        e.seg  = 7'h7F;
        e.tick = 1'b0;
        if ((m_blink && ph >= BF) || presc < BLK) return e;
        e.an[sl] = 1'b0;
        blank = (sl == 3 && m_sh[3] == 4'd0) || (sl == 2 && m_sh[3] == 4'd0 && m_sh[2] == 4'd0);
        e.seg = blank ? 7'h7F : ~glyph_tbl[m_sh[sl]];
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n       = 0;
                m_sh    = '{default: 4'hF};
                m_blink = 1'b0;
                q.delete();
            end else begin
                e = model_out(n);
                n++;
                if (n % FRAME == 0) begin
                    m_sh[3] = d3;
                    m_sh[2] = d2;
                    m_sh[1] = d1;
                    m_sh[0] = d0;
                    m_blink = blink_en;
                end
                e.tick = (n % FRAME == 0);
                q.push_back(e);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_an", 32'(an), 32'hF);
                chk("rst_seg", 32'(seg), 32'h7F);
                chk("rst_tick", 32'(frame_tick), 32'h0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                chk("an", 32'(an), 32'(e.an));
                chk("seg", 32'(seg), 32'(e.seg));
                chk("frame_tick", 32'(frame_tick), 32'(e.tick));
            end
        end
    end

    task automatic set_digits(input logic [3:0] a, b, c, d, input logic bl);
        d3 = a;
        d2 = b;
        d1 = c;
        d0 = d;
        blink_en = bl;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    function automatic logic [3:0] rand_digit();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
        run(3);
        set_digits(4'd1, 4'd2, 4'd5, 4'd0, 1'b0);
        rst_n = 1'b1;
        run(3 * FRAME);

        set_digits(4'd0, 4'd0, 4'd5, 4'd0, 1'b0);
        run(2 * FRAME);
        set_digits(4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
        run(2 * FRAME);

        set_digits(4'd1, 4'd2, 4'd5, 4'd0, 1'b0);
        run(2 * FRAME + FRAME / 2);
        set_digits(4'd9, 4'd9, 4'd9, 4'd0, 1'b0);
        run(2 * FRAME);

        set_digits(4'hE, 4'hA, 4'hA, 4'hF, 1'b1);
        run(10 * FRAME);
        blink_en = 1'b0;
        run(2 * FRAME);

        // Pull reset in the middle of slot 1's lit window.
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((n / DIV) % 4 == 2 && n % DIV == 2) break;
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        run(2);
        rst_n = 1'b1;
        run(3 * FRAME);

        for (int i = 0; i < 60; i++) begin
            set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit(),
                       $urandom_range(0, 2) == 0);
            run($urandom_range(1, 3 * FRAME));
        end
        run(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
